// File: rtl/time_to_bcd_converter_pkg.sv
// Shared constants, FSM encoding and BCD helper
// for the stopwatch time-to-BCD converter.
package time_to_bcd_converter_pkg;

  localparam int TW = 39;
  localparam int CW = $clog2(TW + 1);

  localparam logic [TW-1:0] TICKS_PER_CS = TW'(1000000);
  localparam logic [TW-1:0] CS_PER_MIN   = TW'(6000);
  localparam logic [TW-1:0] CS_PER_SEC   = TW'(100);
  localparam logic [TW-1:0] MAX_MIN      = TW'(99);

  localparam logic [7:0]  DP_MIN_SEC = 8'b0001_0100;
  localparam logic [31:0] BCD_SAT    = 32'h0099_5999;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DIV_CS,
    ST_DIV_MIN,
    ST_DIV_SEC,
    ST_BCD,
    ST_DONE
  } state_e;

  // 0..99 -> two BCD digits; tens found by a compare chain
  function automatic logic [7:0] bin2bcd(input logic [6:0] v);
    logic [3:0] t;
    logic [3:0] u;
    t = 4'd0;
    for (int k = 1; k < 10; k++) begin
      if (v >= 7'(k * 10)) t = 4'(k);
    end
    u = 4'(v - 7'(t) * 7'd10);
    return {t, u};
  endfunction

endpackage

// File: rtl/time_to_bcd_converter_if.sv
// Time/result bundle between the stopwatch side
// (master) and the BCD converter (slave).
interface time_to_bcd_converter_if;
  import time_to_bcd_converter_pkg::*;

  logic          start;
  logic          auto_mode;
  logic [TW-1:0] time_in;
  logic [31:0]   bcd_out;
  logic [7:0]    dp_mask;
  logic          busy;
  logic          done;
  logic          overflow;

  modport master (
    output start, auto_mode, time_in,
    input  bcd_out, dp_mask, busy, done, overflow
  );

  modport slave (
    input  start, auto_mode, time_in,
    output bcd_out, dp_mask, busy, done, overflow
  );

endinterface

// File: rtl/time_to_bcd_converter_div.sv
// TW-bit restoring divider, one quotient bit per cycle.
// The load cycle already performs the first step.
module time_to_bcd_converter_div
  import time_to_bcd_converter_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          load_i,
  input  logic          step_i,
  input  logic [TW-1:0] dividend_i,
  input  logic [TW-1:0] divisor_i,
  output logic [TW-1:0] quotient_o,
  output logic [TW-1:0] remainder_o,
  output logic          valid_o
);

  logic [TW-1:0] quo_q, quo_d;
  logic [TW-1:0] rem_q, rem_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] src_quo, src_rem;
  logic [TW:0]   shf, dif;

  // one shift/subtract step on either fresh operands or the running state
  always_comb begin
    src_quo = load_i ? dividend_i : quo_q;
    src_rem = load_i ? '0 : rem_q;
    shf     = {src_rem, src_quo[TW-1]};
    dif     = shf - {1'b0, divisor_i};
    quo_d   = quo_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    if (load_i || step_i) begin
      rem_d = dif[TW] ? shf[TW-1:0] : dif[TW-1:0];
      quo_d = {src_quo[TW-2:0], ~dif[TW]};
      cnt_d = load_i ? CW'(1) : cnt_q + 1'b1;
    end
  end

  // divider state registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      quo_q <= '0;
      rem_q <= '0;
      cnt_q <= '0;
    end else begin
      quo_q <= quo_d;
      rem_q <= rem_d;
      cnt_q <= cnt_d;
    end
  end

  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;
  assign valid_o     = (cnt_q == CW'(TW));

endmodule

// File: rtl/time_to_bcd_converter.sv
// Binary 10 ns tick count -> packed BCD MM:SS.CC using one
// shared sequential divider for all three divisions.
module time_to_bcd_converter
  import time_to_bcd_converter_pkg::*;
(
  input  logic                         clock,
  input  logic                         rst,
  time_to_bcd_converter_if.slave       bus
);

  state_e        state_q, state_d;
  logic          load, step, valid;
  logic [TW-1:0] dividend, divisor, quo, rem;
  logic [6:0]    min_q, min_d;
  logic          movf_q, movf_d;
  logic [31:0]   bcd_q, bcd_d;
  logic          ovf_q, ovf_d;

  time_to_bcd_converter_div u_div (
    .clk_i       (clock),
    .rst_i       (rst),
    .load_i      (load),
    .step_i      (step),
    .dividend_i  (dividend),
    .divisor_i   (divisor),
    .quotient_o  (quo),
    .remainder_o (rem),
    .valid_o     (valid)
  );

  // sequencing: chain the three divides, then format and publish
  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    step     = 1'b0;
    dividend = quo;
    min_d    = min_q;
    movf_d   = movf_q;
    bcd_d    = bcd_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start || bus.auto_mode) begin
          state_d  = ST_DIV_CS;
          load     = 1'b1;
          dividend = bus.time_in;
        end
      end
      ST_DIV_CS: begin
        if (valid) begin
          state_d  = ST_DIV_MIN;
          load     = 1'b1;
          dividend = quo;
        end else begin
          step = 1'b1;
        end
      end
      ST_DIV_MIN: begin
        if (valid) begin
          state_d  = ST_DIV_SEC;
          load     = 1'b1;
          dividend = rem;
          movf_d   = (quo > MAX_MIN);
          min_d    = quo[6:0];
        end else begin
          step = 1'b1;
        end
      end
      ST_DIV_SEC: begin
        if (valid) state_d = ST_BCD;
        else       step    = 1'b1;
      end
      ST_BCD: begin
        state_d = ST_DONE;
        ovf_d   = movf_q;
        bcd_d   = movf_q ? BCD_SAT :
                  {8'h00, bin2bcd(min_q),
                   bin2bcd(quo[6:0]),
                   bin2bcd(rem[6:0])};
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // divisor follows the division the next step belongs to
  always_comb begin
    unique case (state_d)
      ST_DIV_CS:  divisor = TICKS_PER_CS;
      ST_DIV_MIN: divisor = CS_PER_MIN;
      default:    divisor = CS_PER_SEC;
    endcase
  end

  // state and result registers
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q <= ST_IDLE;
      min_q   <= '0;
      movf_q  <= 1'b0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      min_q   <= min_d;
      movf_q  <= movf_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.bcd_out  = bcd_q;
  assign bus.dp_mask  = DP_MIN_SEC;
  assign bus.busy     = (state_q != ST_IDLE) &&
                        (state_q != ST_DONE);
  assign bus.done     = (state_q == ST_DONE);
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_time_to_bcd_converter.sv
// Directed bench for time_to_bcd_converter with a
// scoreboard of expected BCD results.
module tb_time_to_bcd_converter;
  import time_to_bcd_converter_pkg::*;

  typedef struct packed {
    logic [31:0] bcd;
    logic        ovf;
  } exp_t;

  logic clock = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  time_to_bcd_converter_if bus();

  time_to_bcd_converter dut (
    .clock (clock),
    .rst   (rst),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] to_bcd(input longint v);
    return 8'((v / 10) * 16 + (v % 10));
  endfunction

  function automatic exp_t model(input logic [38:0] t);
    longint cs, m, r;
    exp_t   e;
    cs = longint'(t) / 1000000;
    m  = cs / 6000;
    r  = cs % 6000;
    if (m > 99) begin
      e.bcd = 32'h0099_5999;
      e.ovf = 1'b1;
    end else begin
      e.bcd = {8'h00, to_bcd(m), to_bcd(r / 100), to_bcd(r % 100)};
      e.ovf = 1'b0;
    end
    return e;
  endfunction

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    check({tag, "_sb"}, 32'(sb.size() > 0), 32'd1);
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    check({tag, "_bcd"}, bus.bcd_out, e.bcd);
    check({tag, "_ovf"}, 32'(bus.overflow), 32'(e.ovf));
    check({tag, "_dp"}, 32'(bus.dp_mask), 32'h14);
  endtask

  task automatic quiet(input string tag, input int cyc);
    int nd;
    nd = 0;
    repeat (cyc) begin
      @(posedge clock); #1;
      if (bus.done === 1'b1) nd++;
    end
    check({tag, "_nodone"}, 32'(nd), 32'd0);
  endtask

  task automatic conv(input string tag, input logic [38:0] t,
                      input int poke_at, input logic [38:0] t2);
    int          n;
    logic [31:0] held;
    @(negedge clock);
    bus.time_in = t;
    bus.start   = 1'b1;
    sb.push_back(model(t));
    @(posedge clock); #1;
    bus.start = 1'b0;
    check({tag, "_busy"}, 32'(bus.busy), 32'd1);
    n = 0;
    while (bus.done !== 1'b1 && n < 300) begin
      @(posedge clock); #1;
      n++;
      bus.start = (n == poke_at);
      if (n == poke_at) bus.time_in = t2;
    end
    bus.start = 1'b0;
    check({tag, "_lat"}, 32'(n), 32'd118);
    check({tag, "_busy_done"}, 32'(bus.busy), 32'd0);
    pop_check(tag);
    held = bus.bcd_out;
    @(posedge clock); #1;
    check({tag, "_pulse"}, 32'(bus.done), 32'd0);
    check({tag, "_hold"}, bus.bcd_out, held);
    if (poke_at >= 0) quiet(tag, 130);
  endtask

  initial begin
    int          e, prev, ndone, latch_e;
    logic [31:0] val;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.auto_mode = 1'b0;
    bus.time_in   = '0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_bcd", bus.bcd_out, 32'h0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_ovf", 32'(bus.overflow), 32'd0);
    check("rst_dp", 32'(bus.dp_mask), 32'h14);
    @(negedge clock);
    rst = 1'b0;

    conv("zero", 39'd0, -1, 39'd0);
    conv("s61", 39'd6_123_400_000, -1, 39'd0);
    check("s61_lit", bus.bcd_out, 32'h0001_0123);
    conv("max", 39'h7F_FFFF_FFFF, -1, 39'd0);
    check("max_lit", bus.bcd_out, 32'h0091_3755);
    conv("rnd0", 39'({$urandom, $urandom}), -1, 39'd0);
    conv("rnd1", 39'({$urandom, $urandom}), -1, 39'd0);
    conv("poke", 39'd75_000_000_000, 50, 39'd1_000_000);
    check("poke_lit", bus.bcd_out, 32'h0012_3000);

    @(negedge clock);
    bus.time_in = 39'd12_345_678_900;
    bus.start   = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0;
    repeat (60) begin
      @(posedge clock); #1;
    end
    rst = 1'b1;
    @(posedge clock); #1;
    check("mrst_busy", 32'(bus.busy), 32'd0);
    check("mrst_bcd", bus.bcd_out, 32'h0);
    check("mrst_done", 32'(bus.done), 32'd0);
    check("mrst_ovf", 32'(bus.overflow), 32'd0);
    rst = 1'b0;
    quiet("mrst", 150);

    @(negedge clock);
    bus.auto_mode = 1'b1;
    bus.time_in   = 39'd30_000_000_000;
    sb.push_back(model(bus.time_in));
    @(posedge clock); #1;
    e       = 0;
    prev    = -2;
    ndone   = 0;
    latch_e = -1;
    while (ndone < 3 && e < 500) begin
      if (bus.done === 1'b1) begin
        pop_check("auto");
        val = (prev < 0) ? 32'd118 : 32'd120;
        check("auto_period", 32'(e - ((prev < 0) ? 0 : prev)), val);
        prev = e;
        ndone++;
        if (ndone == 3) bus.auto_mode = 1'b0;
        latch_e = (ndone < 3) ? e + 2 : -1;
      end
      bus.time_in = bus.time_in + 39'd987_654_321;
      if (e + 1 == latch_e) sb.push_back(model(bus.time_in));
      @(posedge clock); #1;
      e++;
    end
    check("auto_count", 32'(ndone), 32'd3);
    quiet("auto_off", 130);
    check("auto_idle", 32'(bus.busy), 32'd0);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
